// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded hold time and one dead cycle
// between owners so that tri-state drivers never overlap.
module bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;
    logic [NUM_REQ-1:0] pen_q, pen_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               tmo_q, tmo_d;

    logic [NUM_REQ-1:0] elig;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      pick_next;
    logic [IW:0]        scan;

    assign elig = req & ~pen_q;

    // First eligible requester at or above rr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan = {1'b0, rr_q} + (IW+1)'(off);
            if (scan >= (IW+1)'(NUM_REQ)) begin
                scan = scan - (IW+1)'(NUM_REQ);
            end
            if (!pick_found && elig[scan[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IW-1:0];
            end
        end
    end

    assign pick_next = (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        tmo_d   = 1'b0;
        pen_d   = pen_q & req;
        unique case (state_q)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    rr_d    = pick_next;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    owner_d = '0;
                end
            end
            GRANT: begin
                // A release in the last allowed cycle wins over the timeout.
                if (!req[owner_q]) begin
                    state_d = TURN;
                    grant_d = '0;
                    owner_d = '0;
                    hold_d  = '0;
                end else if (hold_q == 8'(MAX_HOLD-1)) begin
                    state_d        = TURN;
                    grant_d        = '0;
                    owner_d        = '0;
                    hold_d         = '0;
                    tmo_d          = 1'b1;
                    pen_d[owner_q] = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            rr_q    <= '0;
            pen_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            pen_q   <= pen_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign owner_id    = owner_q;
    assign timeout_err = tmo_q;
    assign busy        = (state_q != IDLE);

endmodule
